// File: rtl/w_bus_arbiter.sv
// w_bus_arbiter: round-robin arbiter sharing one W bus master port among NREQ requesters
//
// Ports:
//   clk, rst         single clock; synchronous active-high reset
//   req_i            per-requester request level, held until its ack_o bit is seen
//   req_write_i      per-requester write flag
//   req_addr_i       flattened addresses, requester i on bits [32i+31:32i]
//   req_data_i       flattened write data, same packing as req_addr_i
//   ack_o            one-hot, one-cycle completion pulse to the winner
//   rsp_data_o       read data for the acked requester, valid with ack_o
//   rsp_err_o        transaction aborted by timeout, valid with ack_o
//   w_addr_o         bus address
//   w_data_o         bus write data
//   w_write_o        bus write enable
//   w_stb_o          bus cycle active
//   w_ack_i          bus completion, only honoured while a bus cycle is active
//   w_data_i         bus read data, sampled together with w_ack_i
//
// Optional feature: define W_ARB_TIMEOUT_EN to abort a bus cycle after TIMEOUT
// strobe cycles without w_ack_i (ack_o with rsp_err_o=1, rsp_data_o=32'hDEADBEEF).
// Without it the bus waits indefinitely and rsp_err_o is tied low.
module w_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   req_write_i,
    input  logic [32*NREQ-1:0] req_addr_i,
    input  logic [32*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic [31:0]       w_addr_o,
    output logic [31:0]       w_data_o,
    output logic              w_write_o,
    output logic              w_stb_o,
    input  logic              w_ack_i,
    input  logic [31:0]       w_data_i
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] g_q;
    logic [PW-1:0] win_d;
    logic [PW-1:0] idx;

    // Scan downward in offset so the requester closest to ptr_q is written last and wins.
    always_comb begin
        win_d = ptr_q;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (req_i[idx]) win_d = idx;
        end
    end

`ifdef W_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = (TW < 8) ? 8 : ((TW > 16) ? 16 : TW);
    logic [CW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            ack_o      <= '0;
            rsp_data_o <= '0;
            w_addr_o   <= '0;
            w_data_o   <= '0;
            w_write_o  <= 1'b0;
            w_stb_o    <= 1'b0;
`ifdef W_ARB_TIMEOUT_EN
            rsp_err_o  <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        g_q       <= win_d;
                        w_addr_o  <= req_addr_i[{win_d, 5'd0} +: 32];
                        w_data_o  <= req_data_i[{win_d, 5'd0} +: 32];
                        w_write_o <= req_write_i[win_d];
                        w_stb_o   <= 1'b1;
                        state_q   <= BUS;
`ifdef W_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                BUS: begin
                    if (w_ack_i) begin
                        w_stb_o   <= 1'b0;
                        w_write_o <= 1'b0;
                        if (!w_write_o) rsp_data_o <= w_data_i;
                        ack_o     <= NREQ'(1) << g_q;
                        state_q   <= DONE;
`ifdef W_ARB_TIMEOUT_EN
                        rsp_err_o <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        w_stb_o    <= 1'b0;
                        w_write_o  <= 1'b0;
                        rsp_data_o <= 32'hDEADBEEF;
                        rsp_err_o  <= 1'b1;
                        ack_o      <= NREQ'(1) << g_q;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                DONE: begin
                    ack_o   <= '0;
                    ptr_q   <= (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w_bus_arbiter.sv
// tb_w_bus_arbiter: randomized and directed checking of w_bus_arbiter against a transaction-level model
module tb_w_bus_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      wr = '0;
    logic [31:0]       addr_a[N];
    logic [31:0]       data_a[N];
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_write;
    logic              w_stb;
    logic              w_ack = 1'b0;
    logic [31:0]       w_rdata = '0;

    int  total = 0;
    int  bad = 0;
    bit  auto_req = 0;
    bit  auto_bus = 0;
    int  waits[N];
    int  dut_log[$];
    int  mod_log[$];

    // model state: who holds the bus and what the outputs must show after the next edge
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_g = 0;
    bit          m_wr = 0;
    bit          m_valid = 0;
    bit          e_stb = 0;
    bit          e_write = 0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_rsp = '0;
    logic [N-1:0] e_ack = '0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = addr_a[i];
            req_data[32*i +: 32] = data_a[i];
        end
    end

    w_bus_arbiter #(.NREQ(N), .TIMEOUT(256)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .req_write_i(wr), .req_addr_i(req_addr), .req_data_i(req_data),
        .ack_o(ack), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .w_addr_o(w_addr), .w_data_o(w_wdata), .w_write_o(w_write), .w_stb_o(w_stb),
        .w_ack_i(w_ack), .w_data_i(w_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Compare at the negedge, then advance the model with the inputs the next posedge will sample.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("stb", 32'(w_stb), 32'(e_stb));
            chk("write", 32'(w_write), 32'(e_write));
            if (e_stb) begin
                chk("addr", w_addr, e_addr);
                chk("wdata", w_wdata, e_wdata);
            end
            chk("ack", 32'(ack), 32'(e_ack));
            if (e_ack != 0) begin
                chk("rsp_data", rsp_data, e_rsp);
                chk("rsp_err", 32'(rsp_err), 32'd0);
            end
            for (int i = 0; i < N; i++) if (ack[i]) dut_log.push_back(i);
        end
        if (rst) begin
            m_phase = 0; m_ptr = 0;
            e_stb = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_rsp = '0; e_ack = '0;
        end else if (m_phase == 0) begin
            if (req != 0) begin
                m_g = -1;
                for (int d = 0; d < N; d++)
                    if (m_g < 0 && req[(m_ptr + d) % N]) m_g = (m_ptr + d) % N;
                mod_log.push_back(m_g);
                e_addr = addr_a[m_g]; e_wdata = data_a[m_g]; e_write = wr[m_g];
                m_wr = wr[m_g]; e_stb = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (w_ack) begin
                e_stb = 0; e_write = 0;
                if (!m_wr) e_rsp = w_rdata;
                e_ack = N'(1) << m_g;
                m_phase = 2;
            end
        end else begin
            e_ack = '0;
            m_ptr = (m_g + 1) % N;
            m_phase = 0;
        end
        m_valid = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_bus) begin
            w_ack = w_stb ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            w_rdata = $urandom;
        end
        if (auto_req) begin
            for (int j = 0; j < N; j++) if (ack[j]) begin
                chk("fair", 32'(waits[j] <= N - 1), 32'd1);
                for (int i = 0; i < N; i++) if (i != j && req[i]) waits[i]++;
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i]) begin
                    addr_a[i] = $urandom; data_a[i] = $urandom; wr[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin req[i] = 1'b1; waits[i] = 0; end
                end
            end
        end
    endtask

    task automatic serve(input bit reraise, input logic [N-1:0] add, output int who);
        who = -1;
        for (int t = 0; t < 20 && who < 0; t++) begin
            cyc();
            w_ack = w_stb;
            if (ack != 0) begin
                for (int i = 0; i < N; i++) if (ack[i]) who = i;
                req[who] = 1'b0;
                req = req | add;
            end
        end
        if (who < 0) begin
            total++; bad++;
            $display("FAIL serve: no ack within 20 cycles, required an ack");
        end else begin
            cyc();
            if (reraise) req[who] = 1'b1;
        end
    endtask

    initial begin
        int who;
        int n0;
        int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
        int mod_exp[14] = '{0, 2, 0, 1, 2, 3, 0, 1, 3, 0, 1, 0, 2, 0};
        for (int i = 0; i < N; i++) begin addr_a[i] = 32'h1000 * i; data_a[i] = 32'hD0 + i; waits[i] = 0; end
        rst = 1; cyc(); cyc();
        chk("rst_stb", 32'(w_stb), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_addr", w_addr, 32'd0);
        chk("rst_rsp", rsp_data, 32'd0);
        chk("rst_write", 32'(w_write), 32'd0);
        rst = 0; cyc();
        // single read by requester 0
        addr_a[0] = 32'h0000_0100; wr[0] = 0; req = 4'b0001;
        cyc();
        chk("rd_stb", 32'(w_stb), 32'd1);
        chk("rd_addr", w_addr, 32'h100);
        chk("rd_write", 32'(w_write), 32'd0);
        cyc(); cyc();
        w_ack = 1; w_rdata = 32'hCAFE_0001;
        cyc();
        chk("rd_ack", 32'(ack), 32'b0001);
        chk("rd_data", rsp_data, 32'hCAFE_0001);
        chk("rd_stb_low", 32'(w_stb), 32'd0);
        req = 0; w_ack = 0;
        cyc();
        chk("rd_ack_once", 32'(ack), 32'd0);
        // single write by requester 2
        addr_a[2] = 32'h0000_0200; data_a[2] = 32'h1234_5678; wr[2] = 1; req = 4'b0100;
        cyc();
        chk("wr_write", 32'(w_write), 32'd1);
        chk("wr_data", w_wdata, 32'h1234_5678);
        chk("wr_addr", w_addr, 32'h200);
        w_ack = 1;
        cyc();
        chk("wr_ack", 32'(ack), 32'b0100);
        chk("wr_rsp_kept", rsp_data, 32'hCAFE_0001);
        req = 0; w_ack = 0; wr[2] = 0;
        cyc();
        // round-robin from a fresh pointer
        rst = 1; cyc(); rst = 0;
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            serve(1, '0, who);
            chk("rr_order", 32'(who), 32'(rr_exp[k]));
        end
        req = 4'b1001;
        serve(1, '0, who); chk("rr_to3", 32'(who), 32'd3);
        serve(0, '0, who); chk("rr_wrap0", 32'(who), 32'd0);
        // requester 0 raises in the cycle requester 1 is acked
        req = 4'b0010;
        serve(0, 4'b0001, who); chk("sim_1", 32'(who), 32'd1);
        serve(0, '0, who); chk("sim_0", 32'(who), 32'd0);
        // reset in the middle of a bus cycle
        req = 4'b0100; w_ack = 0;
        cyc();
        chk("mid_stb", 32'(w_stb), 32'd1);
        rst = 1;
        cyc();
        chk("mid_rst_stb", 32'(w_stb), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        rst = 0; req = 0; w_ack = 1;
        cyc();
        chk("late_ack_stb", 32'(w_stb), 32'd0);
        chk("late_ack_ack", 32'(ack), 32'd0);
        cyc();
        chk("late_ack_ack2", 32'(ack), 32'd0);
        w_ack = 0; req = 4'b0101;
        serve(0, '0, who); chk("post_rst", 32'(who), 32'd0);
        req = 0;
        cyc(); cyc();
        for (int k = 0; k < 14; k++)
            chk("model_pin", 32'(k < mod_log.size() ? mod_log[k] : -1), 32'(mod_exp[k]));
        // randomized traffic
        n0 = dut_log.size();
        auto_req = 1; auto_bus = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst = ($urandom_range(0, 299) == 0);
            if (rst) for (int i = 0; i < N; i++) waits[i] = 0;
        end
        auto_req = 0; auto_bus = 0; rst = 0;
        chk("rand_acks", 32'(dut_log.size() - n0 > 200), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/w_bus_arbiter.md
# w_bus_arbiter

Round-robin arbiter that shares the single W bus master port between up to four CPU-side requesters, typically the per-thread FETCH units. It accepts one request at a time, drives the bus address, data and write strobe, and waits for `W_ACK`. It then returns read data plus a one-cycle acknowledge to the winning requester. Both sides run on one clock domain, `clk`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..4.
- `TIMEOUT`, default 256: number of `W_STB` cycles without `W_ACK` before abort. Used only with `W_ARB_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock for both the requester side and the bus side.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req`, in, NREQ: per-requester request level. Held until that requester's `ack` is seen.
- `req_write`, in, NREQ: per-requester write flag.
- `req_addr`, in, 32*NREQ: flattened addresses. Requester i uses bits [32i+31:32i].
- `req_data`, in, 32*NREQ: flattened write data, same packing as `req_addr`.
- `ack`, out, NREQ: one-hot completion pulse, one cycle long.
- `rsp_data`, out, 32: read data for the acked requester. Valid while `ack` is high.
- `rsp_err`, out, 1: transaction aborted by timeout. Valid while `ack` is high.
- `W_ADDR`, out, 32: bus address.
- `W_DATA_O`, out, 32: bus write data.
- `W_WRITE`, out, 1: bus write enable.
- `W_STB`, out, 1: bus cycle active.
- `W_ACK`, in, 1: bus completion.
- `W_DATA_I`, in, 32: bus read data. Sampled in the same cycle `W_ACK` is high.

## Operation
State machine: IDLE -> BUS -> DONE -> IDLE.

- **IDLE**
  - If `req` is nonzero, choose the winner `g`: the first set bit scanning upward from `ptr`, wrapping NREQ-1 -> 0.
  - Register `g`. Load `W_ADDR`, `W_DATA_O` and `W_WRITE` from requester g's slice. Set `W_STB`=1. Clear the timeout counter. Go to BUS.
- **BUS**
  - While `W_ACK`=0, hold all bus outputs stable.
  - On `W_ACK`=1:
    - set `W_STB`=0 and `W_WRITE`=0;
    - set `rsp_data` to `W_DATA_I` for a read, or leave it unchanged for a write;
    - set `rsp_err`=0 and `ack[g]`=1;
    - go to DONE.
- **DONE**
  - Set `ack`=0 and `ptr`=(g+1) mod NREQ. Go to IDLE.
- **Requester rule:** drop `req[i]` at the clock edge where it samples `ack[i]`=1. A `req[i]` still high in the following IDLE cycle is treated as a new request.
- **Non-granted requesters:** keep their `req` high. Their `req_addr`, `req_data` and `req_write` slices are ignored until they are granted.
- **Fairness:** a requester that is continuously asserted waits at most NREQ-1 transactions.
- **`W_ACK` outside BUS:** ignored.
- **`req` bits ≥ NREQ:** none exist; widths equal NREQ.
- **Reset values:**
  - `ack`=0, `rsp_data`=0, `rsp_err`=0;
  - `W_ADDR`=0, `W_DATA_O`=0, `W_WRITE`=0, `W_STB`=0;
  - `ptr`=0, state=IDLE.
- **Reset mid-transaction:** the transaction is abandoned. `W_STB` is 0 in the cycle after `rst`, and no `ack` is issued.

## Timing
- Request seen in IDLE at edge N → `W_STB`=1 from N+1.
- `W_ACK` sampled at edge M → `ack`/`rsp_data` valid in cycle M+1 (registered) → IDLE at M+2.
- Minimum occupancy is 3 cycles per transaction, with zero-wait `W_ACK` in the first BUS cycle.
- Back-to-back transactions: the next grant's `W_STB` rises 2 cycles after the previous `W_ACK`.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- **`W_ARB_TIMEOUT_EN` defined:**
  - An 8..16-bit counter increments each BUS cycle.
  - When the count reaches TIMEOUT-1 with no `W_ACK`, the arbiter sets `W_STB`=0 and `ack[g]`=1, with `rsp_err`=1 and `rsp_data`=32'hDEADBEEF, then goes to DONE.
  - A `W_ACK` in the same cycle as the terminal count wins: it completes as a normal transaction with no error.
- **Not defined:**
  - BUS waits indefinitely.
  - `rsp_err` is tied to 0.
  - No counter logic is synthesized.

## Test plan
- **Single read:** `req`=4'b0001, `req_addr[31:0]`=32'h0000_0100; bus returns `W_ACK` after 3 cycles with `W_DATA_I`=32'hCAFE_0001 → `W_ADDR`=32'h100, `W_WRITE`=0; `ack`=4'b0001 for exactly one cycle with `rsp_data`=32'hCAFE_0001.
- **Single write:** requester 2 writes 32'h1234_5678 to 32'h0000_0200 → `W_WRITE`=1, `W_DATA_O`=32'h1234_5678 while `W_STB`=1; `ack`=4'b0100.
- **Round-robin:** all four `req` held high, each re-raised after its ack → grant order 0,1,2,3,0,1. Then with only `req[3]` and `req[0]` pending after a grant to 3 → 0 is granted next.
- **Simultaneous events:** requester 1 is acked; in the same cycle `req[0]` rises → `ptr`=2, so `req[0]` is granted next with no lost request.
- **Reset mid-BUS:** `rst` pulsed for 1 cycle while `W_STB`=1 → `W_STB`=0 and `ack`=0 on the next cycle; a late `W_ACK` is ignored; a subsequent request is granted to requester 0 from `ptr`=0.
- **Timeout (`W_ARB_TIMEOUT_EN`, `TIMEOUT`=8):** `W_ACK` held low → `ack[g]` rises after 8 BUS cycles with `rsp_err`=1 and `rsp_data`=32'hDEADBEEF; `W_ACK` arriving on the 8th cycle → normal completion with `rsp_err`=0.
